// File: rtl/cpa_pkg.sv
// Shared types, defaults and helpers for the pipelined carry-propagate adder.
// Stage records are sized to MAX_W, so WIDTH must not exceed MAX_W.
package cpa_pkg;

   localparam int unsigned DEF_WIDTH       = 17;
   localparam int unsigned DEF_SEG_W       = 6;
   localparam int unsigned DEF_APPROX_BITS = 4;
   localparam int unsigned MAX_W           = 64;

   function automatic int unsigned cpa_nseg(input int unsigned width, input int unsigned seg_w);
      return (width + seg_w - 1) / seg_w;
   endfunction

   // a/b keep only the segments not yet added; already-consumed bits are zeroed
   typedef struct packed {
      logic             valid;
      logic             approx;
      logic             carry;
      logic [MAX_W-1:0] psum;
      logic [MAX_W-1:0] a;
      logic [MAX_W-1:0] b;
   } stage_t;

endpackage

// File: rtl/cpa_segment.sv
// Combinational ripple full-adder chain of parametrised width.
module cpa_segment #(
   parameter int unsigned W = 6
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int unsigned i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[W];
   end

endmodule

// File: rtl/pipelined_cp_adder.sv
// Segmented pipelined adder, one SEG_W-bit segment per stage, global stall.
// Define CPA_APPROX_EN to enable per-transaction approximate low bits.
module pipelined_cp_adder
   import cpa_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned SEG_W       = DEF_SEG_W,
   parameter int unsigned APPROX_BITS = DEF_APPROX_BITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             approx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned NSEG = cpa_nseg(WIDTH, SEG_W);

   logic   advance;
   stage_t head;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   always_comb begin
      head                = '0;
      head.valid          = in_valid;
      head.a[WIDTH-1:0]   = in1;
      head.b[WIDTH-1:0]   = in2;
      head.carry          = cin;
`ifdef CPA_APPROX_EN
      // Low bits become OR results held in psum; the operand pair at bit
      // APPROX_BITS-1 is rewritten so the chain emits exactly a&b as carry.
      if (approx) begin
         head.approx                   = 1'b1;
         head.carry                    = 1'b0;
         head.psum[APPROX_BITS-1:0]    = in1[APPROX_BITS-1:0] | in2[APPROX_BITS-1:0];
         head.a[APPROX_BITS-1:0]       = '0;
         head.b[APPROX_BITS-1:0]       = '0;
         head.a[APPROX_BITS-1]         = in1[APPROX_BITS-1] & in2[APPROX_BITS-1];
         head.b[APPROX_BITS-1]         = in1[APPROX_BITS-1] & in2[APPROX_BITS-1];
      end
`endif
   end

`ifndef CPA_APPROX_EN
   logic unused_cfg;
   assign unused_cfg = approx | (APPROX_BITS == 0);
`endif

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int unsigned LO = k * SEG_W;
      localparam int unsigned WK = (k == NSEG - 1) ? WIDTH - LO : SEG_W;

      stage_t          s_in;
      stage_t          s_nxt;
      stage_t          q;
      logic [WK-1:0]   seg_s;
      logic            seg_co;

      if (k == 0) begin : g_first
         assign s_in = head;
      end else begin : g_next
         assign s_in = g_stage[k-1].q;
      end

      cpa_segment #(.W(WK)) u_seg (
         .a  (s_in.a[LO +: WK]),
         .b  (s_in.b[LO +: WK]),
         .ci (s_in.carry),
         .s  (seg_s),
         .co (seg_co)
      );

      always_comb begin
         s_nxt                = s_in;
         s_nxt.a[LO +: WK]    = '0;
         s_nxt.b[LO +: WK]    = '0;
         s_nxt.psum[LO +: WK] = seg_s;
         s_nxt.carry          = seg_co;
`ifdef CPA_APPROX_EN
         if (s_in.approx) begin
            for (int unsigned i = LO; i < LO + WK; i++) begin
               if (i < APPROX_BITS) s_nxt.psum[i] = s_in.psum[i];
            end
         end
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (advance) begin
            q <= s_nxt;
         end
      end
   end

   assign out_valid = g_stage[NSEG-1].q.valid;
   assign sum       = g_stage[NSEG-1].q.psum[WIDTH-1:0];
   assign cout      = g_stage[NSEG-1].q.carry;

   logic unused_tail;
   assign unused_tail = ^g_stage[NSEG-1].q;

endmodule

// File: tb/tb_pipelined_cp_adder.sv
// Scoreboard bench for pipelined_cp_adder at WIDTH=17, SEG_W=6, APPROX_BITS=4.
module tb_pipelined_cp_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] in1;
   logic [16:0] in2;
   logic        cin;
   logic        approx;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] sum;
   logic        cout;

   int checks = 0;
   int errors = 0;
   logic [17:0] exp_q[$];

   pipelined_cp_adder #(
      .WIDTH       (17),
      .SEG_W       (6),
      .APPROX_BITS (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
      .approx    (approx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] model(input logic [16:0] a, input logic [16:0] b,
                                         input logic c, input logic ap);
      logic [17:0] r;
      r = {1'b0, a} + {1'b0, b} + {17'd0, c};
`ifdef CPA_APPROX_EN
      if (ap) begin
         logic [3:0]  lo;
         logic [13:0] hi;
         lo = a[3:0] | b[3:0];
         hi = {1'b0, a[16:4]} + {1'b0, b[16:4]} + {13'd0, a[3] & b[3]};
         r  = {hi, lo};
      end
`else
      if (ap) r = r;
`endif
      return r;
   endfunction

   task automatic cycle();
      if (in_valid) exp_q.push_back(model(in1, in2, cin, approx));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [16:0] a, input logic [16:0] b, input logic c, input logic ap);
      in_valid = 1'b1;
      in1      = a;
      in2      = b;
      cin      = c;
      approx   = ap;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; approx = 1'b0; out_ready = 1'b1;
      #12;
      checks++;
      if ({out_valid, sum, cout} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%0b sum=%h cout=%0b want 0/0/0", out_valid, sum, cout);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %0b want 1", in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_carry_chain();
      logic [17:0] e;
      drive(17'h1FFFF, 17'h00001, 1'b0, 1'b0);
      cycle();
      in_valid = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL carry_early got out_valid=%0b want 0", out_valid);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL carry_latency got out_valid=%0b want 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL carry_value got %h want %h", {cout, sum}, e);
         end
      end
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [16:0] va[4] = '{17'h00001, 17'h0FFFF, 17'h10000, 17'h00000};
      logic [16:0] vb[4] = '{17'h00001, 17'h00001, 17'h10000, 17'h00000};
      logic        vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [17:0] e;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if (i <= 4) drive(va[i-1], vb[i-1], vc[i-1], 1'b0);
         else in_valid = 1'b0;
         cycle();
         checks++;
         if (out_valid !== (i >= 3 && i <= 6)) begin
            errors++;
            $display("FAIL b2b_valid cycle %0d got %0b want %0b", i, out_valid, (i >= 3 && i <= 6));
         end else if (out_valid) begin
            e = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== e) begin
               errors++;
               $display("FAIL b2b_data cycle %0d got %h want %h", i, {cout, sum}, e);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [17:0] e;
      int got = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(17'h01234 + 17'(i * 17'h01111), 17'h0F0F0 - 17'(i), 1'(i), 1'b0);
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || {cout, sum} !== exp_q[0]) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got ready=%0b valid=%0b data=%h want 0/1/%h",
                     i, in_ready, out_valid, {cout, sum}, exp_q[0]);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got++;
            checks++;
            if ({cout, sum} !== e) begin
               errors++;
               $display("FAIL stall_drain item %0d got %h want %h", got, {cout, sum}, e);
            end
         end
         cycle();
      end
      checks++;
      if (got != 3 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_count got %0d results valid=%0b want 3/0", got, out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      logic [17:0] e;
      out_ready = 1'b1;
      drive(17'h00101, 17'h00202, 1'b0, 1'b0); cycle();
      drive(17'h00303, 17'h00404, 1'b1, 1'b0); cycle();
      in_valid = 1'b0;
      drive(17'h00505, 17'h00606, 1'b0, 1'b0); cycle();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 17'd0 || cout !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset got valid=%0b sum=%h cout=%0b ready=%0b want 0/0/0/1",
                  out_valid, sum, cout, in_ready);
      end
      exp_q.delete();
      @(posedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_result cycle %0d got out_valid=%0b want 0", i, out_valid);
         end
      end
      drive(17'h00005, 17'h00003, 1'b0, 1'b0);
      cycle();
      in_valid = 1'b0;
      cycle();
      cycle();
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL post_reset_txn got out_valid=%0b want 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL post_reset_data got %h want %h", {cout, sum}, e);
         end
      end
      cycle();
   endtask

   task automatic test_approx();
      logic [17:0] e;
      int got = 0;
      out_ready = 1'b1;
      drive(17'h0000F, 17'h0000B, 1'b0, 1'b1); cycle();
      drive(17'h0000F, 17'h0000B, 1'b0, 1'b0); cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got++;
            checks++;
            if ({cout, sum} !== e) begin
               errors++;
               $display("FAIL approx_data item %0d got %h want %h", got, {cout, sum}, e);
            end
         end
         cycle();
      end
      checks++;
      if (got != 2) begin
         errors++;
         $display("FAIL approx_count got %0d want 2", got);
      end
   endtask

   task automatic test_random();
      logic [17:0] e;
      int got = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i < 24) drive(17'($urandom), 17'($urandom), 1'($urandom), 1'($urandom));
         else in_valid = 1'b0;
         cycle();
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL random_extra got %h want none", {cout, sum});
            end else begin
               e = exp_q.pop_front();
               got++;
               if ({cout, sum} !== e) begin
                  errors++;
                  $display("FAIL random_data item %0d got %h want %h", got, {cout, sum}, e);
               end
            end
         end
      end
      checks++;
      if (got != 24 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_count got %0d left %0d want 24/0", got, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_carry_chain();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_approx();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
